// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle unsigned 8-bit multiply/divide unit; optional multiply early-out under MULDIV_EARLY_OUT_EN
module muldiv_unit #(
    parameter int WIDTH  = 8,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              op,
    input  logic [WIDTH-1:0]  opa,
    input  logic [WIDTH-1:0]  opb,
    input  logic [REG_AW-1:0] dest,
    output logic              busy,
    output logic              done,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_rd,
    output logic [WIDTH-1:0]  result,
    output logic [WIDTH-1:0]  result_hi,
    output logic              div_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state;
    logic               op_q;
    logic [CW-1:0]      cnt;

    // multiply datapath: multiplicand shifts left, multiplier shifts right
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;

    // divide datapath: dividend shifts out MSB-first into the partial remainder
    logic [WIDTH-1:0]   dvd;
    logic [WIDTH-1:0]   dvr;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;

    logic [2*WIDTH-1:0] acc_nx;
    logic [WIDTH:0]     div_trial;
    logic               div_keep;
    logic [WIDTH-1:0]   div_diff;
    logic [WIDTH-1:0]   rem_nx;
    logic [WIDTH-1:0]   quo_nx;
    logic               last_iter;
    logic               mul_finish;

    // write enable is simply the done pulse
    assign wb_we = done;

    // one shift-add / restoring-divide iteration computed from the current state
    always_comb begin
        acc_nx = acc;
        if (mplier[0]) begin
            acc_nx = acc + mcand;
        end
        // the remainder stays below the divisor, so the trial value fits in WIDTH+1 bits
        div_trial = {rem, dvd[WIDTH-1]};
        div_keep  = (div_trial >= {1'b0, dvr});
        // when kept, the true difference is below the divisor, so truncation is exact
        div_diff  = div_trial[WIDTH-1:0] - dvr;
        rem_nx    = div_keep ? div_diff : div_trial[WIDTH-1:0];
        quo_nx    = {quo[WIDTH-2:0], div_keep};
        last_iter = (cnt == CW'(WIDTH - 1));
`ifdef MULDIV_EARLY_OUT_EN
        // no multiplier bits left to consume after this iteration
        mul_finish = last_iter || (mplier[WIDTH-1:1] == '0);
`else
        mul_finish = last_iter;
`endif
    end

    // control FSM with registered status outputs and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            op_q      <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            dvd       <= '0;
            dvr       <= '0;
            rem       <= '0;
            quo       <= '0;
            wb_rd     <= '0;
            result    <= '0;
            result_hi <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_RUN;
                        busy     <= 1'b1;
                        op_q     <= op;
                        wb_rd    <= dest;
                        div_zero <= 1'b0;
                        cnt      <= '0;
                        acc      <= '0;
                        mcand    <= {{WIDTH{1'b0}}, opa};
                        mplier   <= opb;
                        dvd      <= opa;
                        dvr      <= opb;
                        rem      <= '0;
                        quo      <= '0;
                    end
                end

                S_RUN: begin
                    cnt <= cnt + 1'b1;
                    if (op_q) begin
                        if (dvr == '0) begin
                            // divide by zero short-circuits after one cycle; dividend is still unshifted
                            state     <= S_DONE;
                            done      <= 1'b1;
                            div_zero  <= 1'b1;
                            result    <= '1;
                            result_hi <= dvd;
                        end else begin
                            rem <= rem_nx;
                            quo <= quo_nx;
                            dvd <= {dvd[WIDTH-2:0], 1'b0};
                            if (last_iter) begin
                                state     <= S_DONE;
                                done      <= 1'b1;
                                result    <= quo_nx;
                                result_hi <= rem_nx;
                            end
                        end
                    end else begin
                        acc    <= acc_nx;
                        mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
                        mplier <= {1'b0, mplier[WIDTH-1:1]};
                        if (mul_finish) begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            result    <= acc_nx[WIDTH-1:0];
                            result_hi <= acc_nx[2*WIDTH-1:WIDTH];
                        end
                    end
                end

                S_DONE: begin
                    // start is not sampled here, so a restart needs a full idle cycle
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed vector bench for muldiv_unit
`timescale 1ns/1ps
module tb_muldiv_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       op = 1'b0;
    logic [7:0] opa = 8'h00;
    logic [7:0] opb = 8'h00;
    logic [2:0] dest = 3'd0;
    logic       busy, done, wb_we, div_zero;
    logic [2:0] wb_rd;
    logic [7:0] result, result_hi;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(8), .REG_AW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .opa       (opa),
        .opb       (opb),
        .dest      (dest),
        .busy      (busy),
        .done      (done),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .result    (result),
        .result_hi (result_hi),
        .div_zero  (div_zero)
    );

    typedef struct {
        logic       op;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] rd;
        logic [7:0] res;
        logic [7:0] hi;
        logic       dz;
        int         lat;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_cmp = 0;

    function automatic int mul_lat(input logic [7:0] b);
        int l;
        l = 8;
`ifdef MULDIV_EARLY_OUT_EN
        l = 1;
        for (int i = 0; i < 8; i++) if (b[i]) l = i + 1;
`endif
        return l;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        @(negedge clk);
        start = 1'b1; op = v.op; opa = v.a; opb = v.b; dest = v.rd;
        @(negedge clk);
        start = 1'b0;
        op = 1'($urandom); opa = 8'($urandom); opb = 8'($urandom); dest = 3'($urandom);
        chk($sformatf("v%0d busy_after_start", idx), busy, 1);
        cyc = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("v%0d latency", idx), cyc, v.lat);
        chk($sformatf("v%0d wb_we", idx), wb_we, 1);
        chk($sformatf("v%0d result", idx), result, v.res);
        chk($sformatf("v%0d result_hi", idx), result_hi, v.hi);
        chk($sformatf("v%0d wb_rd", idx), wb_rd, v.rd);
        chk($sformatf("v%0d div_zero", idx), div_zero, v.dz);
        @(negedge clk);
        chk($sformatf("v%0d done_one_cycle", idx), done, 0);
        chk($sformatf("v%0d busy_fall", idx), busy, 0);
        chk($sformatf("v%0d result_hold", idx), result, v.res);
        chk($sformatf("v%0d hi_hold", idx), result_hi, v.hi);
        chk($sformatf("v%0d dz_hold", idx), div_zero, v.dz);
        n_vec++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int pulses;
        int wes;
        vecs[0]  = '{1'b0, 8'h0D, 8'h0B, 3'd3, 8'h8F, 8'h00, 1'b0, mul_lat(8'h0B)};
        vecs[1]  = '{1'b0, 8'hFF, 8'hFF, 3'd7, 8'h01, 8'hFE, 1'b0, mul_lat(8'hFF)};
        vecs[2]  = '{1'b1, 8'hC8, 8'h07, 3'd2, 8'h1C, 8'h04, 1'b0, 8};
        vecs[3]  = '{1'b1, 8'h5A, 8'h00, 3'd5, 8'hFF, 8'h5A, 1'b1, 1};
        vecs[4]  = '{1'b0, 8'h33, 8'h01, 3'd1, 8'h33, 8'h00, 1'b0, mul_lat(8'h01)};
        vecs[5]  = '{1'b0, 8'h33, 8'h04, 3'd4, 8'hCC, 8'h00, 1'b0, mul_lat(8'h04)};
        vecs[6]  = '{1'b0, 8'h33, 8'h80, 3'd6, 8'h80, 8'h19, 1'b0, mul_lat(8'h80)};
        vecs[7]  = '{1'b0, 8'h00, 8'h00, 3'd0, 8'h00, 8'h00, 1'b0, mul_lat(8'h00)};
        vecs[8]  = '{1'b1, 8'hFF, 8'h01, 3'd3, 8'hFF, 8'h00, 1'b0, 8};
        vecs[9]  = '{1'b1, 8'h07, 8'h09, 3'd2, 8'h00, 8'h07, 1'b0, 8};
        vecs[10] = '{1'b1, 8'hFF, 8'hFF, 3'd7, 8'h01, 8'h00, 1'b0, 8};
        vecs[11] = '{1'b0, 8'h12, 8'h34, 3'd5, 8'hA8, 8'h03, 1'b0, mul_lat(8'h34)};
        vecs[12] = '{1'b1, 8'h64, 8'h0A, 3'd1, 8'h0A, 8'h00, 1'b0, 8};

        // reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst wb_we", wb_we, 0);
        chk("rst div_zero", div_zero, 0);
        chk("rst result", result, 0);
        chk("rst result_hi", result_hi, 0);
        chk("rst wb_rd", wb_rd, 0);
        rst_n = 1'b1;
        n_vec++;

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], i);
        end

        // start re-pulsed during RUN and during DONE must be ignored
        @(negedge clk);
        start = 1'b1; op = 1'b0; opa = 8'h0D; opb = 8'h0B; dest = 3'd3;
        @(negedge clk);
        pulses = 0;
        for (int c = 1; c <= 20; c++) begin
            start = 1'b0;
            if (c == 2 || c == 3) begin
                start = 1'b1; op = 1'b1; opa = 8'h5A; opb = 8'h00; dest = 3'd6;
            end
            @(negedge clk);
            if (done) begin
                pulses++;
                chk("busy_restart result", result, 8'h8F);
                chk("busy_restart wb_rd", wb_rd, 3);
                start = 1'b1; op = 1'b1; opa = 8'h5A; opb = 8'h00; dest = 3'd6;
            end
        end
        start = 1'b0;
        chk("busy_restart done_count", pulses, 1);
        chk("busy_restart idle", busy, 0);
        chk("busy_restart div_zero", div_zero, 0);
        n_vec++;

        // reset asserted at iteration 4 aborts the operation
        @(negedge clk);
        start = 1'b1; op = 1'b1; opa = 8'hC8; opb = 8'h07; dest = 3'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort wb_we", wb_we, 0);
        chk("abort result", result, 0);
        chk("abort result_hi", result_hi, 0);
        chk("abort wb_rd", wb_rd, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wes = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (wb_we) wes++;
        end
        chk("abort no_wb_we", wes, 0);
        n_vec++;

        // fresh operation after the abort
        run_vec(vecs[2], 100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
